// File: rtl/roce_dma_pkg.sv
// Shared types and constants for the RoCE-to-DMA write splitter.
package roce_dma_pkg;

  localparam int CMD_W      = 96;
  localparam int DEST_W     = 4;
  localparam int DATA_BYTES = 64;

  typedef struct packed {
    logic [31:0] len;
    logic [63:0] vaddr;
  } dma_cmd_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CMD,
    ST_DATA,
    ST_DRAIN
  } state_t;

endpackage

// File: rtl/roce_chunk_calc.sv
// Combinational chunk sizing: min(remaining, MAX_BYTES) and the beat count it occupies.
// Zero latency; no handshakes.
module roce_chunk_calc #(
  parameter int MAX_BYTES  = 4096,
  parameter int DATA_BYTES = 64,
  parameter int BEAT_W     = 7
) (
  input  logic [31:0]       remaining,
  output logic [31:0]       chunk_len,
  output logic [BEAT_W-1:0] chunk_beats
);

  localparam logic [31:0] MAX_LEN = 32'(MAX_BYTES);
  localparam int          SHIFT   = $clog2(DATA_BYTES);

  always_comb begin
    chunk_len   = (remaining > MAX_LEN) ? MAX_LEN : remaining;
    // chunk_len never exceeds MAX_BYTES, so the beat count fits in BEAT_W bits
    chunk_beats = BEAT_W'((chunk_len + 32'(DATA_BYTES - 1)) >> SHIFT);
  end

endmodule

// File: rtl/roce_dma_wr_splitter.sv
// Splits RoCE write commands into <=MAX_BYTES DMA commands, marks chunk ends with last, polices length.
// Cmd accept -> DMA cmd next cycle; data is zero-latency pass-through in DATA; ready follows DMA ready.
module roce_dma_wr_splitter
  import roce_dma_pkg::*;
#(
  parameter int MAX_BYTES  = 4096,
  parameter int DATA_BYTES = 64
) (
  input  logic                    net_clk,
  input  logic                    net_reset,

  input  logic                    s_axis_wr_cmd_valid,
  output logic                    s_axis_wr_cmd_ready,
  input  logic [CMD_W-1:0]        s_axis_wr_cmd_data,
  input  logic [DEST_W-1:0]       s_axis_wr_cmd_dest,

  input  logic                    s_axis_wr_data_valid,
  output logic                    s_axis_wr_data_ready,
  input  logic [DATA_BYTES*8-1:0] s_axis_wr_data_data,
  input  logic [DATA_BYTES-1:0]   s_axis_wr_data_keep,
  input  logic                    s_axis_wr_data_last,
  input  logic [DEST_W-1:0]       s_axis_wr_data_dest,

  output logic                    m_axis_dma_wr_cmd_valid,
  input  logic                    m_axis_dma_wr_cmd_ready,
  output logic [CMD_W-1:0]        m_axis_dma_wr_cmd_data,
  output logic [DEST_W-1:0]       m_axis_dma_wr_cmd_dest,

  output logic                    m_axis_dma_wr_data_valid,
  input  logic                    m_axis_dma_wr_data_ready,
  output logic [DATA_BYTES*8-1:0] m_axis_dma_wr_data_data,
  output logic [DATA_BYTES-1:0]   m_axis_dma_wr_data_keep,
  output logic                    m_axis_dma_wr_data_last,
  output logic [DEST_W-1:0]       m_axis_dma_wr_data_dest,

  output logic [31:0]             len_err_count_data,
  output logic                    len_err_count_valid
);

  localparam int BEAT_W = $clog2(MAX_BYTES / DATA_BYTES) + 1;

  state_t            state, state_nxt;
  logic [63:0]       addr;
  logic [31:0]       remaining;
  logic [BEAT_W-1:0] chunk_beats_left;
  logic [DEST_W-1:0] dest;
  logic [31:0]       err_cnt;
  logic              err_vld;

  dma_cmd_t          in_cmd;
  dma_cmd_t          out_cmd;
  logic [31:0]       chunk_len;
  logic [BEAT_W-1:0] chunk_beats;
  logic [31:0]       rem_after;
  logic              chunk_end;
  logic              data_hs;
  logic              load_cmd, load_chunk, beat_taken, chunk_done, err_inc;
  logic              unused_data_dest;

  roce_chunk_calc #(
    .MAX_BYTES  (MAX_BYTES),
    .DATA_BYTES (DATA_BYTES),
    .BEAT_W     (BEAT_W)
  ) u_chunk_calc (
    .remaining   (remaining),
    .chunk_len   (chunk_len),
    .chunk_beats (chunk_beats)
  );

  assign in_cmd           = dma_cmd_t'(s_axis_wr_cmd_data);
  assign rem_after        = remaining - chunk_len;
  assign chunk_end        = (chunk_beats_left == BEAT_W'(1));
  assign data_hs          = s_axis_wr_data_valid && s_axis_wr_data_ready;
  // Input-side dest is superseded by the dest latched from the command.
  assign unused_data_dest = ^s_axis_wr_data_dest;

  always_comb begin
    out_cmd.len   = chunk_len;
    out_cmd.vaddr = addr;
  end

  assign m_axis_dma_wr_cmd_data  = out_cmd;
  assign m_axis_dma_wr_cmd_dest  = dest;
  assign m_axis_dma_wr_data_data = s_axis_wr_data_data;
  assign m_axis_dma_wr_data_keep = s_axis_wr_data_keep;
  assign m_axis_dma_wr_data_dest = dest;

  assign len_err_count_data  = err_cnt;
  assign len_err_count_valid = err_vld;

  always_ff @(posedge net_clk) begin
    if (net_reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt                = state;
    s_axis_wr_cmd_ready      = 1'b0;
    s_axis_wr_data_ready     = 1'b0;
    m_axis_dma_wr_cmd_valid  = 1'b0;
    m_axis_dma_wr_data_valid = 1'b0;
    m_axis_dma_wr_data_last  = 1'b0;
    load_cmd                 = 1'b0;
    load_chunk               = 1'b0;
    beat_taken               = 1'b0;
    chunk_done               = 1'b0;
    err_inc                  = 1'b0;

    unique case (state)
      ST_IDLE: begin
        s_axis_wr_cmd_ready = 1'b1;
        if (s_axis_wr_cmd_valid) begin
          if (in_cmd.len != 32'd0) begin
            load_cmd  = 1'b1;
            state_nxt = ST_CMD;
          end else begin
            err_inc   = 1'b1;
            state_nxt = ST_DRAIN;
          end
        end
      end

      ST_CMD: begin
        m_axis_dma_wr_cmd_valid = 1'b1;
        if (m_axis_dma_wr_cmd_ready) begin
          load_chunk = 1'b1;
          state_nxt  = ST_DATA;
        end
      end

      ST_DATA: begin
        m_axis_dma_wr_data_valid = s_axis_wr_data_valid;
        s_axis_wr_data_ready     = m_axis_dma_wr_data_ready;
        m_axis_dma_wr_data_last  = chunk_end || s_axis_wr_data_last;
        if (data_hs) begin
          beat_taken = 1'b1;
          if (chunk_end) begin
            chunk_done = 1'b1;
            if (rem_after == 32'd0) begin
              if (s_axis_wr_data_last) begin
                state_nxt = ST_IDLE;
              end else begin
                err_inc   = 1'b1;
                state_nxt = ST_DRAIN;
              end
            end else if (s_axis_wr_data_last) begin
              // Packet ended on a chunk boundary with chunks still owed: short packet.
              err_inc   = 1'b1;
              state_nxt = ST_IDLE;
            end else begin
              state_nxt = ST_CMD;
            end
          end else if (s_axis_wr_data_last) begin
            err_inc   = 1'b1;
            state_nxt = ST_IDLE;
          end
        end
      end

      ST_DRAIN: begin
        s_axis_wr_data_ready = 1'b1;
        if (s_axis_wr_data_valid && s_axis_wr_data_last) begin
          state_nxt = ST_IDLE;
        end
      end

      default: state_nxt = ST_IDLE;
    endcase

    // Nothing handshakes while reset is held, whatever state is still registered.
    if (net_reset) begin
      s_axis_wr_cmd_ready      = 1'b0;
      s_axis_wr_data_ready     = 1'b0;
      m_axis_dma_wr_cmd_valid  = 1'b0;
      m_axis_dma_wr_data_valid = 1'b0;
      m_axis_dma_wr_data_last  = 1'b0;
      load_cmd                 = 1'b0;
      load_chunk               = 1'b0;
      beat_taken               = 1'b0;
      chunk_done               = 1'b0;
      err_inc                  = 1'b0;
    end
  end

  always_ff @(posedge net_clk) begin
    if (net_reset) begin
      addr             <= '0;
      remaining        <= '0;
      chunk_beats_left <= '0;
      dest             <= '0;
    end else begin
      if (load_cmd) begin
        addr      <= in_cmd.vaddr;
        remaining <= in_cmd.len;
        dest      <= s_axis_wr_cmd_dest;
      end
      if (load_chunk) begin
        chunk_beats_left <= chunk_beats;
      end else if (beat_taken) begin
        chunk_beats_left <= chunk_beats_left - BEAT_W'(1);
      end
      if (chunk_done) begin
        addr      <= addr + 64'(chunk_len);
        remaining <= rem_after;
      end
    end
  end

  always_ff @(posedge net_clk) begin
    if (net_reset) begin
      err_cnt <= '0;
      err_vld <= 1'b0;
    end else begin
      err_vld <= 1'b0;
      if (err_inc && (err_cnt != 32'hFFFF_FFFF)) begin
        err_cnt <= err_cnt + 32'd1;
        err_vld <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_roce_dma_wr_splitter.sv
// Randomized bench for roce_dma_wr_splitter with a packet-level reference model and per-cycle compare.
module tb_roce_dma_wr_splitter;
  import roce_dma_pkg::*;

  localparam int MAXB = 4096;
  localparam int BPC  = MAXB / DATA_BYTES;

  logic                    net_clk;
  logic                    net_reset;
  logic                    s_axis_wr_cmd_valid, s_axis_wr_cmd_ready;
  logic [CMD_W-1:0]        s_axis_wr_cmd_data;
  logic [DEST_W-1:0]       s_axis_wr_cmd_dest;
  logic                    s_axis_wr_data_valid, s_axis_wr_data_ready;
  logic [DATA_BYTES*8-1:0] s_axis_wr_data_data;
  logic [DATA_BYTES-1:0]   s_axis_wr_data_keep;
  logic                    s_axis_wr_data_last;
  logic [DEST_W-1:0]       s_axis_wr_data_dest;
  logic                    m_axis_dma_wr_cmd_valid, m_axis_dma_wr_cmd_ready;
  logic [CMD_W-1:0]        m_axis_dma_wr_cmd_data;
  logic [DEST_W-1:0]       m_axis_dma_wr_cmd_dest;
  logic                    m_axis_dma_wr_data_valid, m_axis_dma_wr_data_ready;
  logic [DATA_BYTES*8-1:0] m_axis_dma_wr_data_data;
  logic [DATA_BYTES-1:0]   m_axis_dma_wr_data_keep;
  logic                    m_axis_dma_wr_data_last;
  logic [DEST_W-1:0]       m_axis_dma_wr_data_dest;
  logic [31:0]             len_err_count_data;
  logic                    len_err_count_valid;

  roce_dma_wr_splitter #(.MAX_BYTES(MAXB), .DATA_BYTES(DATA_BYTES)) dut (
    .net_clk                  (net_clk),
    .net_reset                (net_reset),
    .s_axis_wr_cmd_valid      (s_axis_wr_cmd_valid),
    .s_axis_wr_cmd_ready      (s_axis_wr_cmd_ready),
    .s_axis_wr_cmd_data       (s_axis_wr_cmd_data),
    .s_axis_wr_cmd_dest       (s_axis_wr_cmd_dest),
    .s_axis_wr_data_valid     (s_axis_wr_data_valid),
    .s_axis_wr_data_ready     (s_axis_wr_data_ready),
    .s_axis_wr_data_data      (s_axis_wr_data_data),
    .s_axis_wr_data_keep      (s_axis_wr_data_keep),
    .s_axis_wr_data_last      (s_axis_wr_data_last),
    .s_axis_wr_data_dest      (s_axis_wr_data_dest),
    .m_axis_dma_wr_cmd_valid  (m_axis_dma_wr_cmd_valid),
    .m_axis_dma_wr_cmd_ready  (m_axis_dma_wr_cmd_ready),
    .m_axis_dma_wr_cmd_data   (m_axis_dma_wr_cmd_data),
    .m_axis_dma_wr_cmd_dest   (m_axis_dma_wr_cmd_dest),
    .m_axis_dma_wr_data_valid (m_axis_dma_wr_data_valid),
    .m_axis_dma_wr_data_ready (m_axis_dma_wr_data_ready),
    .m_axis_dma_wr_data_data  (m_axis_dma_wr_data_data),
    .m_axis_dma_wr_data_keep  (m_axis_dma_wr_data_keep),
    .m_axis_dma_wr_data_last  (m_axis_dma_wr_data_last),
    .m_axis_dma_wr_data_dest  (m_axis_dma_wr_data_dest),
    .len_err_count_data       (len_err_count_data),
    .len_err_count_valid      (len_err_count_valid)
  );

  typedef struct {
    logic [CMD_W-1:0]  cmd;
    logic [DEST_W-1:0] dest;
  } exp_cmd_t;

  typedef struct {
    logic [DATA_BYTES*8-1:0] data;
    logic [DATA_BYTES-1:0]   keep;
    logic                    last;
    logic [DEST_W-1:0]       dest;
  } exp_beat_t;

  exp_cmd_t                cmd_q[$];
  exp_beat_t               beat_q[$];
  int unsigned             err_q[$];
  int unsigned             model_err;
  logic [DATA_BYTES*8-1:0] pkt_data[256];
  logic [DATA_BYTES-1:0]   pkt_keep[256];
  int                      errors = 0;
  int                      checks = 0;
  bit                      bp = 0;

  initial begin
    net_clk = 0;
    forever #5 net_clk = ~net_clk;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not complete, errors=%0d", errors);
    $fatal(1);
  end

  task automatic chk(input string name, input logic [DATA_BYTES*8-1:0] act, input logic [DATA_BYTES*8-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Packet-level reference: chunk list, forwarded beats with last flags, and error outcome.
  task automatic model_packet(input int unsigned len, input logic [63:0] va, input logic [DEST_W-1:0] dst, input int nb);
    int unsigned need, fwd, rem, cl, start;
    logic [63:0] a;
    logic lst;
    need = (len + DATA_BYTES - 1) / DATA_BYTES;
    fwd  = (len == 0) ? 0 : ((nb < int'(need)) ? nb : need);
    rem = len; a = va; start = 0;
    while (rem > 0 && start < nb) begin
      cl = (rem > MAXB) ? MAXB : rem;
      cmd_q.push_back('{cmd: {cl, a}, dest: dst});
      start += (cl + DATA_BYTES - 1) / DATA_BYTES;
      a     += 64'(cl);
      rem   -= cl;
    end
    for (int i = 0; i < int'(fwd); i++) begin
      lst = ((i + 1) % BPC == 0) || (i + 1 == int'(need)) || (i == nb - 1);
      beat_q.push_back('{data: pkt_data[i], keep: pkt_keep[i], last: lst, dest: dst});
    end
    if (len == 0 || nb != int'(need)) begin
      if (model_err != 32'hFFFF_FFFF) model_err++;
      err_q.push_back(model_err);
    end
  endtask

  task automatic gen_data(input int nb);
    for (int i = 0; i < nb; i++) begin
      for (int w = 0; w < DATA_BYTES / 4; w++) pkt_data[i][w*32 +: 32] = $urandom();
      pkt_keep[i] = {$urandom(), $urandom()};
    end
  endtask

  task automatic tick();
    @(posedge net_clk);
    #1;
  endtask

  task automatic send_cmd(input int unsigned len, input logic [63:0] va, input logic [DEST_W-1:0] dst);
    int n = 0;
    s_axis_wr_cmd_valid = 1;
    s_axis_wr_cmd_data  = {len, va};
    s_axis_wr_cmd_dest  = dst;
    forever begin
      @(negedge net_clk);
      if (s_axis_wr_cmd_ready) break;
      n++;
      if (n > 2000) begin
        checks++; errors++;
        $display("FAIL cmd_handshake: ready never seen, got 0 required 1");
        break;
      end
    end
    tick();
    s_axis_wr_cmd_valid = 0;
  endtask

  task automatic send_beats(input int nb, input int upto);
    int n;
    for (int i = 0; i < upto; i++) begin
      if ($urandom_range(0, 3) == 0) tick();
      s_axis_wr_data_valid = 1;
      s_axis_wr_data_data  = pkt_data[i];
      s_axis_wr_data_keep  = pkt_keep[i];
      s_axis_wr_data_last  = (i == nb - 1);
      s_axis_wr_data_dest  = 4'($urandom_range(0, 15));
      n = 0;
      forever begin
        @(negedge net_clk);
        if (s_axis_wr_data_ready) break;
        n++;
        if (n > 2000) begin
          checks++; errors++;
          $display("FAIL data_handshake: ready never seen on beat %0d, got 0 required 1", i);
          break;
        end
      end
      tick();
      s_axis_wr_data_valid = 0;
      s_axis_wr_data_last  = 0;
    end
  endtask

  task automatic flush_model();
    cmd_q.delete();
    beat_q.delete();
    err_q.delete();
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    forever begin
      @(negedge net_clk);
      if (cmd_q.size() == 0 && beat_q.size() == 0 && err_q.size() == 0 && s_axis_wr_cmd_ready) break;
      n++;
      if (n > 3000) begin
        checks++; errors++;
        $display("FAIL %s_idle: timeout with %0d cmds %0d beats %0d errs pending", name, cmd_q.size(), beat_q.size(), err_q.size());
        flush_model();
        break;
      end
    end
    chk({name, "_err_count"}, len_err_count_data, model_err);
    tick();
  endtask

  // Per-cycle compare of every output handshake against the model queues.
  initial begin
    exp_cmd_t  ec;
    exp_beat_t eb;
    forever begin
      @(negedge net_clk);
      if (!net_reset) begin
        if (m_axis_dma_wr_cmd_valid && m_axis_dma_wr_cmd_ready) begin
          if (cmd_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_cmd: got %0h, none required", m_axis_dma_wr_cmd_data);
          end else begin
            ec = cmd_q.pop_front();
            chk("cmd_data", m_axis_dma_wr_cmd_data, ec.cmd);
            chk("cmd_dest", m_axis_dma_wr_cmd_dest, ec.dest);
          end
        end
        if (m_axis_dma_wr_data_valid && m_axis_dma_wr_data_ready) begin
          if (beat_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_beat: got data %0h, none required", m_axis_dma_wr_data_data[63:0]);
          end else begin
            eb = beat_q.pop_front();
            chk("beat_data", m_axis_dma_wr_data_data, eb.data);
            chk("beat_keep", m_axis_dma_wr_data_keep, eb.keep);
            chk("beat_last", m_axis_dma_wr_data_last, eb.last);
            chk("beat_dest", m_axis_dma_wr_data_dest, eb.dest);
          end
        end
        if (len_err_count_valid) begin
          if (err_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_err_pulse: got count %0d, no pulse required", len_err_count_data);
          end else begin
            chk("err_pulse_count", len_err_count_data, err_q.pop_front());
          end
        end
      end
    end
  end

  initial begin
    m_axis_dma_wr_cmd_ready  = 0;
    m_axis_dma_wr_data_ready = 0;
    forever begin
      tick();
      m_axis_dma_wr_cmd_ready  = bp ? ($urandom_range(0, 3) != 0) : 1'b1;
      m_axis_dma_wr_data_ready = bp ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
  end

  initial begin
    int unsigned len, need;
    int          nb, nl;
    logic [63:0] va, base;
    logic [DEST_W-1:0] d;

    net_reset = 1;
    s_axis_wr_cmd_valid = 0; s_axis_wr_cmd_data = '0; s_axis_wr_cmd_dest = '0;
    s_axis_wr_data_valid = 0; s_axis_wr_data_data = '0; s_axis_wr_data_keep = '0;
    s_axis_wr_data_last = 0; s_axis_wr_data_dest = '0;
    model_err = 0;
    repeat (2) @(posedge net_clk);
    @(negedge net_clk);
    chk("rst_cmd_ready", s_axis_wr_cmd_ready, 0);
    chk("rst_data_ready", s_axis_wr_data_ready, 0);
    chk("rst_cmd_valid", m_axis_dma_wr_cmd_valid, 0);
    chk("rst_data_valid", m_axis_dma_wr_data_valid, 0);
    chk("rst_err_valid", len_err_count_valid, 0);
    chk("rst_err_count", len_err_count_data, 0);
    tick();
    net_reset = 0;
    @(negedge net_clk);
    chk("idle_cmd_ready", s_axis_wr_cmd_ready, 1);
    tick();

    // len 200, 4 beats
    gen_data(4);
    model_packet(200, 64'h1000, 4'h3, 4);
    chk("m1_ncmd", cmd_q.size(), 1);
    chk("m1_cmd", cmd_q[0].cmd, {32'd200, 64'h1000});
    chk("m1_nbeat", beat_q.size(), 4);
    chk("m1_lasts", {beat_q[3].last, beat_q[2].last, beat_q[1].last, beat_q[0].last}, 4'b1000);
    send_cmd(200, 64'h1000, 4'h3);
    chk("cmd_latency", m_axis_dma_wr_cmd_valid, 1);
    send_beats(4, 4);
    wait_idle("t1");

    // len 10000 split into three chunks
    base = 64'h0000_0001_0000_0000;
    gen_data(157);
    model_packet(10000, base, 4'h5, 157);
    chk("m2_ncmd", cmd_q.size(), 3);
    chk("m2_cmd0", cmd_q[0].cmd, {32'd4096, base});
    chk("m2_cmd1", cmd_q[1].cmd, {32'd4096, base + 64'd4096});
    chk("m2_cmd2", cmd_q[2].cmd, {32'd1808, base + 64'd8192});
    nl = 0;
    foreach (beat_q[i]) if (beat_q[i].last) nl++;
    chk("m2_nlast", nl, 3);
    chk("m2_last64", beat_q[63].last, 1);
    chk("m2_last128", beat_q[127].last, 1);
    chk("m2_last157", beat_q[156].last, 1);
    send_cmd(10000, base, 4'h5);
    send_beats(157, 157);
    wait_idle("t2");

    // short packet: len 256, last on beat 2
    gen_data(2);
    model_packet(256, 64'h2000, 4'h7, 2);
    chk("m3_nbeat", beat_q.size(), 2);
    chk("m3_last", beat_q[1].last, 1);
    send_cmd(256, 64'h2000, 4'h7);
    send_beats(2, 2);
    wait_idle("t3");
    chk("t3_count_lit", len_err_count_data, 1);

    // long packet: len 128, 5 beats
    gen_data(5);
    model_packet(128, 64'h3000, 4'h9, 5);
    chk("m4_nbeat", beat_q.size(), 2);
    chk("m4_last", beat_q[1].last, 1);
    send_cmd(128, 64'h3000, 4'h9);
    send_beats(5, 5);
    wait_idle("t4");
    chk("t4_count_lit", len_err_count_data, 2);

    // zero-length command
    gen_data(1);
    model_packet(0, 64'h4000, 4'h1, 1);
    chk("m5_ncmd", cmd_q.size(), 0);
    chk("m5_nbeat", beat_q.size(), 0);
    send_cmd(0, 64'h4000, 4'h1);
    send_beats(1, 1);
    wait_idle("t5");
    chk("t5_count_lit", len_err_count_data, 3);

    // random packets with back-pressure
    bp = 1;
    for (int p = 0; p < 25; p++) begin
      len  = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 12000);
      need = (len + DATA_BYTES - 1) / DATA_BYTES;
      if (len == 0) nb = $urandom_range(1, 3);
      else nb = ($urandom_range(0, 2) == 0) ? $urandom_range(1, need + 3) : int'(need);
      va = {$urandom(), $urandom()};
      if ($urandom_range(0, 4) == 0) va = 64'hFFFF_FFFF_FFFF_F000 + 64'($urandom_range(0, 4095));
      d = 4'($urandom_range(0, 15));
      gen_data(nb);
      model_packet(len, va, d, nb);
      send_cmd(len, va, d);
      send_beats(nb, nb);
      wait_idle("rnd");
    end

    // reset in the middle of the second chunk
    va = 64'h0000_0000_8000_0000;
    gen_data(157);
    model_packet(10000, va, 4'hA, 157);
    send_cmd(10000, va, 4'hA);
    send_beats(157, 70);
    s_axis_wr_data_valid = 1;
    s_axis_wr_data_data  = pkt_data[70];
    s_axis_wr_data_last  = 0;
    net_reset = 1;
    flush_model();
    model_err = 0;
    @(negedge net_clk);
    chk("mid_rst_data_valid", m_axis_dma_wr_data_valid, 0);
    chk("mid_rst_data_ready", s_axis_wr_data_ready, 0);
    tick();
    tick();
    net_reset = 0;
    s_axis_wr_data_valid = 0;
    @(negedge net_clk);
    chk("post_rst_cmd_valid", m_axis_dma_wr_cmd_valid, 0);
    chk("post_rst_data_valid", m_axis_dma_wr_data_valid, 0);
    chk("post_rst_err_valid", len_err_count_valid, 0);
    chk("post_rst_err_count", len_err_count_data, 0);
    chk("post_rst_cmd_ready", s_axis_wr_cmd_ready, 1);
    tick();

    gen_data(5);
    model_packet(300, 64'h5000, 4'h2, 5);
    send_cmd(300, 64'h5000, 4'h2);
    send_beats(5, 5);
    wait_idle("after_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
